itm_monitor: RTL and testbench

//  Interframe-space monitor, directly downstream of the overload/error frame maker (OE_MAKER).
//  - Consumes its F_ITMSS hand-back (active-low) and the decoder's EOF_DONE.
//  - Tracks the 3-bit intermission, bus integration and bus idle.
//  - Drives the active-low F_OVRLD request that starts OE_MAKER: reactive overloads and

---
 rtl/can_pkg.sv | 26 ++
 rtl/itm_monitor.sv | 173 +++++++++++++++++
 tb/tb_itm_monitor.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared CAN-controller definitions: interframe-space monitor states, bus levels
// and default timing constants used by the monitor, the overload/error frame
// maker and the decoder.
package can_pkg;

  // Interframe-space monitor states; the encoding is visible on the debug port.
  typedef enum logic [2:0] {
    INTEGRATE = 3'd0,
    IDLE      = 3'd1,
    FRAME     = 3'd2,
    ITM       = 3'd3,
    OVLD_WAIT = 3'd4
  } state_e;

  // Sampled bus levels.
  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  // Default timing constants, in CAN bit times.
  localparam int DEF_INTEG_BITS   = 11;
  localparam int DEF_ITM_BITS     = 3;
  localparam int DEF_MAX_REQ_OVLD = 2;
  localparam int DEF_OVLD_TIMEOUT = 64;
  localparam int DEF_CNT_W        = 7;

endpackage : can_pkg

// File: rtl/itm_monitor.sv
// Interframe-space monitor. Tracks bus integration, intermission and bus idle,
// requests overload frames from the overload/error frame maker (reactive and
// receiver-requested) and flags start-of-frame. Clocked by the sample-point strobe.
module itm_monitor
  import can_pkg::*;
#(
  parameter int INTEG_BITS   = DEF_INTEG_BITS,
  parameter int ITM_BITS     = DEF_ITM_BITS,
  parameter int MAX_REQ_OVLD = DEF_MAX_REQ_OVLD,
  parameter int OVLD_TIMEOUT = DEF_OVLD_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       EOF_DONE,
  input  logic       F_ITMSS,
  input  logic       BUSY_RX,
  output logic       F_OVRLD,
  output logic       F_SOF,
  output logic       BUS_IDLE,
  output logic       ITM_ACTIVE,
  output logic [2:0] STATE_O
);

  localparam int REQ_W = $clog2(MAX_REQ_OVLD + 1);

  localparam logic [CNT_W-1:0] INTEG_LAST = CNT_W'(INTEG_BITS - 1);
  localparam logic [CNT_W-1:0] ITM_LAST   = CNT_W'(ITM_BITS - 1);
  localparam logic [CNT_W-1:0] OVLD_LAST  = CNT_W'(OVLD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [REQ_W-1:0] REQ_MAX    = REQ_W'(MAX_REQ_OVLD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REQ_W-1:0] req_cnt_q, req_cnt_d;
  logic             f_ovrld_q, f_ovrld_d;
  logic             f_sof_q, f_sof_d;
  logic             bus_idle_q, bus_idle_d;
  logic             itm_active_q, itm_active_d;

  logic             frame_evt;
  logic             ovld_grant;
  logic [CNT_W-1:0] cnt_inc;

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_cnt_d = req_cnt_q;
    f_ovrld_d = 1'b1;
    f_sof_d   = 1'b0;

    // EOF_DONE and F_ITMSS on the same bit are one end-of-frame event.
    frame_evt  = EOF_DONE || !F_ITMSS;
    ovld_grant = BUSY_RX && (req_cnt_q < REQ_MAX);
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      INTEGRATE: begin
        if (RX == RECESSIVE) begin
          if (cnt_q == INTEG_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end

      IDLE: begin
        if (RX == DOMINANT) begin
          state_d   = FRAME;
          f_sof_d   = 1'b1;
          req_cnt_d = '0;
        end
      end

      FRAME: begin
        if (frame_evt) begin
          cnt_d = '0;
          if (ovld_grant) begin
            state_d   = OVLD_WAIT;
            f_ovrld_d = 1'b0;
            req_cnt_d = req_cnt_q + 1'b1;
          end else begin
            state_d = ITM;
          end
        end
      end

      ITM: begin
        if (cnt_q >= ITM_LAST) begin
          // Last intermission bit: dominant is SOF, recessive means bus idle.
          cnt_d     = '0;
          req_cnt_d = '0;
          if (RX == DOMINANT) begin
            state_d = FRAME;
            f_sof_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (RX == DOMINANT) begin
          // Dominant in an early intermission bit: reactive overload.
          state_d   = OVLD_WAIT;
          f_ovrld_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      OVLD_WAIT: begin
        // A hand-back on the bit right after our own request cannot be the
        // delimiter of that overload frame, so it is not acted on; this also
        // keeps F_OVRLD from going low on two consecutive bits.
        if (!F_ITMSS && f_ovrld_q) begin
          cnt_d = '0;
          if (ovld_grant) begin
            f_ovrld_d = 1'b0;
            req_cnt_d = req_cnt_q + 1'b1;
          end else begin
            state_d = ITM;
          end
        end else if (cnt_q >= OVLD_LAST) begin
          state_d = INTEGRATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d   = INTEGRATE;
        cnt_d     = '0;
        req_cnt_d = '0;
      end
    endcase

    bus_idle_d   = (state_d == IDLE);
    itm_active_d = (state_d == ITM);
  end

  // State, counters and registered outputs; reset wins over every input.
  always_ff @(posedge SP) begin
    if (reset) begin
      state_q      <= INTEGRATE;
      cnt_q        <= '0;
      req_cnt_q    <= '0;
      f_ovrld_q    <= 1'b1;
      f_sof_q      <= 1'b0;
      bus_idle_q   <= 1'b0;
      itm_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_cnt_q    <= req_cnt_d;
      f_ovrld_q    <= f_ovrld_d;
      f_sof_q      <= f_sof_d;
      bus_idle_q   <= bus_idle_d;
      itm_active_q <= itm_active_d;
    end
  end

  assign F_OVRLD    = f_ovrld_q;
  assign F_SOF      = f_sof_q;
  assign BUS_IDLE   = bus_idle_q;
  assign ITM_ACTIVE = itm_active_q;
  assign STATE_O    = state_q;

endmodule : itm_monitor

// File: tb/tb_itm_monitor.sv
// Directed bench for itm_monitor. Each stimulus step queues the hand-computed
// outputs expected right after the edge that samples it; an independent monitor
// pops and compares them one bit time later.
module tb_itm_monitor;
  import can_pkg::*;

  logic       SP;
  logic       reset;
  logic       RX;
  logic       EOF_DONE;
  logic       F_ITMSS;
  logic       BUSY_RX;
  logic       F_OVRLD;
  logic       F_SOF;
  logic       BUS_IDLE;
  logic       ITM_ACTIVE;
  logic [2:0] STATE_O;

  typedef struct {
    logic       ovrld_n;
    logic       sof;
    logic       idle;
    logic       itm;
    logic [2:0] st;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  itm_monitor dut (
    .SP         (SP),
    .reset      (reset),
    .RX         (RX),
    .EOF_DONE   (EOF_DONE),
    .F_ITMSS    (F_ITMSS),
    .BUSY_RX    (BUSY_RX),
    .F_OVRLD    (F_OVRLD),
    .F_SOF      (F_SOF),
    .BUS_IDLE   (BUS_IDLE),
    .ITM_ACTIVE (ITM_ACTIVE),
    .STATE_O    (STATE_O)
  );

  initial begin
    SP = 1'b0;
    forever #5 SP = ~SP;
  end

  // Drive one bit on the falling edge and queue the outputs expected after the next rising edge.
  task automatic step(input logic rst, input logic rx, input logic eof, input logic itmss_n,
                      input logic busy, input logic e_ovrld_n, input logic e_sof,
                      input logic e_idle, input logic e_itm, input logic [2:0] e_st,
                      input string name);
    exp_t e;
    @(negedge SP);
    reset    = rst;
    RX       = rx;
    EOF_DONE = eof;
    F_ITMSS  = itmss_n;
    BUSY_RX  = busy;
    e.ovrld_n = e_ovrld_n;
    e.sof     = e_sof;
    e.idle    = e_idle;
    e.itm     = e_itm;
    e.st      = e_st;
    e.name    = name;
    sb_q.push_back(e);
  endtask

  // Quiet bus bit with no events: rx only.
  task automatic bit_only(input logic rx, input logic e_idle, input logic e_itm,
                          input logic [2:0] e_st, input string name);
    step(1'b0, rx, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, e_idle, e_itm, e_st, name);
  endtask

  // Eleven recessive bits from INTEGRATE with cnt=0: only the last one reaches IDLE.
  task automatic integrate_to_idle(input string name);
    for (int i = 0; i < 10; i++) bit_only(1'b1, 1'b0, 1'b0, INTEGRATE, name);
    bit_only(1'b1, 1'b1, 1'b0, IDLE, name);
  endtask

  // Scoreboard monitor: compare whenever an expectation is pending.
  initial begin
    exp_t       e;
    logic [6:0] got;
    logic [6:0] want;
    forever begin
      @(posedge SP);
      #1;
      if (sb_q.size() > 0) begin
        e    = sb_q.pop_front();
        got  = {F_OVRLD, F_SOF, BUS_IDLE, ITM_ACTIVE, STATE_O};
        want = {e.ovrld_n, e.sof, e.idle, e.itm, e.st};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL %s: got ovrld_n/sof/idle/itm/state=%b required=%b", e.name, got, want);
        end else begin
          $display("ok   %s: ovrld_n/sof/idle/itm/state=%b", e.name, got);
        end
      end
    end
  end

  initial begin
    int waited;
    reset    = 1'b1;
    RX       = 1'b1;
    EOF_DONE = 1'b0;
    F_ITMSS  = 1'b1;
    BUSY_RX  = 1'b0;

    // 1. reset values, even with every input active
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, INTEGRATE, "reset");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, INTEGRATE, "reset_hold");
    // 10 recessive, one dominant restart, then 11 recessive
    for (int i = 0; i < 10; i++) bit_only(1'b1, 1'b0, 1'b0, INTEGRATE, "integ_run10");
    bit_only(1'b0, 1'b0, 1'b0, INTEGRATE, "integ_dominant_restart");
    integrate_to_idle("integ_run11");

    // 2. frame, EOF, clean intermission into idle
    bit_only(1'b1, 1'b1, 1'b0, IDLE, "idle_recessive");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, FRAME, "sof_from_idle");
    bit_only(1'b1, 1'b0, 1'b0, FRAME, "frame_bit");
    bit_only(1'b0, 1'b0, 1'b0, FRAME, "frame_bit");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ITM, "eof_to_itm");
    bit_only(1'b1, 1'b0, 1'b1, ITM, "itm_bit1");
    bit_only(1'b1, 1'b0, 1'b1, ITM, "itm_bit2");
    bit_only(1'b1, 1'b1, 1'b0, IDLE, "itm_bit3_idle");

    // 3. reactive overload on intermission bit 2, hand-back returns to ITM with cnt=0
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, FRAME, "sof_from_idle");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ITM, "eof_to_itm");
    bit_only(1'b1, 1'b0, 1'b1, ITM, "itm_bit1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OVLD_WAIT, "reactive_ovld");
    bit_only(1'b0, 1'b0, 1'b0, OVLD_WAIT, "ovrld_pulse_ends");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ITM, "itmss_to_itm");
    bit_only(1'b1, 1'b0, 1'b1, ITM, "itm_cnt0_bit1");
    bit_only(1'b1, 1'b0, 1'b1, ITM, "itm_cnt1_bit2");
    bit_only(1'b1, 1'b1, 1'b0, IDLE, "itm_cnt2_idle");

    // 4. BUSY_RX held over three events: two requested overloads, then ITM
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, FRAME, "sof_from_idle");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OVLD_WAIT, "busy_evt1_ovld");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OVLD_WAIT, "eof_ignored_in_wait");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OVLD_WAIT, "busy_evt2_ovld");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OVLD_WAIT, "ovrld_pulse_ends");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ITM, "busy_evt3_itm");

    // 5. intermission 1,1,0 -> SOF on bit 3
    bit_only(1'b1, 1'b0, 1'b1, ITM, "itm_bit1");
    bit_only(1'b1, 1'b0, 1'b1, ITM, "itm_bit2");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, FRAME, "itm_bit3_sof");
    // EOF_DONE and F_ITMSS together count once: overload budget lasts two more events
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OVLD_WAIT, "both_evt_ovld1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OVLD_WAIT, "ovrld_pulse_ends");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OVLD_WAIT, "both_evt_ovld2");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OVLD_WAIT, "ovrld_pulse_ends");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ITM, "both_evt_itm");
    bit_only(1'b1, 1'b0, 1'b1, ITM, "itm_bit1");
    bit_only(1'b1, 1'b0, 1'b1, ITM, "itm_bit2");
    bit_only(1'b1, 1'b1, 1'b0, IDLE, "itm_bit3_idle");

    // 6. overload wait timeout after 64 bits
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, FRAME, "sof_from_idle");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OVLD_WAIT, "busy_ovld");
    for (int i = 0; i < 63; i++) bit_only(1'b0, 1'b0, 1'b0, OVLD_WAIT, "ovld_wait_bit");
    bit_only(1'b0, 1'b0, 1'b0, INTEGRATE, "ovld_timeout");

    // reset drops a pending SOF
    integrate_to_idle("reinteg");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, INTEGRATE, "reset_drops_sof");
    // reset on the edge that would request an overload
    integrate_to_idle("reinteg");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, FRAME, "sof_from_idle");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, INTEGRATE, "reset_drops_ovrld");
    // reset while F_OVRLD is low
    integrate_to_idle("reinteg");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, FRAME, "sof_from_idle");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OVLD_WAIT, "busy_ovld");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, INTEGRATE, "reset_during_ovrld");
    bit_only(1'b1, 1'b0, 1'b0, INTEGRATE, "after_reset");

    // drain the scoreboard, bounded
    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(posedge SP);
      #2;
      waited++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_itm_monitor
